// File: rtl/ws2812_src_arbiter.sv
// N-source front end for ws2812_ctrl: frame-aligned source switching with an
// optional all-off blank frame, plus per-source key gating.
module ws2812_src_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int SEL_W           = 2,
  parameter int KEY_W           = 5,
  parameter int NUM_W           = 6,
  parameter int DATA_W          = 24,
  parameter int LED_CNT         = 64,
  parameter int BLANK_ON_SWITCH = 1
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic [SEL_W-1:0]            mode_req,
  input  logic [KEY_W-1:0]            key_in,
  input  logic [NUM_SRC-1:0]          src_start,
  input  logic [NUM_SRC*NUM_W-1:0]    src_num,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic                        cfg_start,
  output logic                        ws2812_start,
  output logic [NUM_W-1:0]            cfg_num,
  output logic [DATA_W-1:0]           cfg_data,
  output logic [NUM_SRC*KEY_W-1:0]    key_out,
  output logic [SEL_W-1:0]            active_sel,
  output logic                        switching
);

  localparam int CNT_W = $clog2(LED_CNT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FRAME    = 2'd1,
    S_BLANK_GO = 2'd2,
    S_BLANK    = 2'd3
  } state_t;

  state_t                     state_r, state_nxt_s;
  logic [SEL_W-1:0]           active_sel_r, active_sel_nxt_s;
  logic [SEL_W-1:0]           pend_sel_r, pend_sel_nxt_s;
  logic                       pend_r, pend_nxt_s;
  logic [CNT_W-1:0]           cnt_r, cnt_nxt_s;
  logic                       start_nxt_s;
  logic                       ws2812_start_r;
  logic                       switching_r, switching_nxt_s;
  logic [NUM_SRC*KEY_W-1:0]   key_out_r, key_nxt_s;
  logic                       req_ok_s;
  logic                       blank_s;

  assign req_ok_s = (32'(mode_req) < 32'(NUM_SRC));
  assign blank_s  = (state_r == S_BLANK_GO) || (state_r == S_BLANK);

  // Next-state, request tracking and frame LED counting
  always_comb begin
    state_nxt_s      = state_r;
    active_sel_nxt_s = active_sel_r;
    pend_nxt_s       = pend_r;
    pend_sel_nxt_s   = pend_sel_r;
    cnt_nxt_s        = cnt_r;
    start_nxt_s      = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (pend_r) begin
          active_sel_nxt_s = pend_sel_r;
          pend_nxt_s       = 1'b0;
          if (BLANK_ON_SWITCH != 0) begin
            state_nxt_s = S_BLANK_GO;
            start_nxt_s = 1'b1;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else if (src_start[active_sel_r]) begin
          state_nxt_s = S_FRAME;
          start_nxt_s = 1'b1;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FRAME, S_BLANK: begin
        if (cfg_start) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(LED_CNT - 1)) begin
            state_nxt_s = S_IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      S_BLANK_GO: begin
        state_nxt_s = S_BLANK;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase

    // Compared against the post-switch owner so a request equal to the new owner clears pending
    if (req_ok_s && (mode_req != active_sel_nxt_s)) begin
      pend_nxt_s     = 1'b1;
      pend_sel_nxt_s = mode_req;
    end else if (req_ok_s) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
  end

  // Registered status flag mirrors the next pending/blank condition
  always_comb begin
    switching_nxt_s = pend_nxt_s || (state_nxt_s == S_BLANK_GO) || (state_nxt_s == S_BLANK);
  end

  // Key routing to the owning source; muted while a switch is pending or blanking
  always_comb begin
    key_nxt_s = {(NUM_SRC*KEY_W){1'b0}};
    if (!(pend_r || blank_s)) begin
      key_nxt_s[32'(active_sel_r)*KEY_W +: KEY_W] = key_in;
    end else begin
      key_nxt_s = {(NUM_SRC*KEY_W){1'b0}};
    end
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r        <= S_IDLE;
      active_sel_r   <= {SEL_W{1'b0}};
      pend_r         <= 1'b0;
      pend_sel_r     <= {SEL_W{1'b0}};
      cnt_r          <= {CNT_W{1'b0}};
      ws2812_start_r <= 1'b0;
      switching_r    <= 1'b0;
      key_out_r      <= {(NUM_SRC*KEY_W){1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      active_sel_r   <= active_sel_nxt_s;
      pend_r         <= pend_nxt_s;
      pend_sel_r     <= pend_sel_nxt_s;
      cnt_r          <= cnt_nxt_s;
      ws2812_start_r <= start_nxt_s;
      switching_r    <= switching_nxt_s;
      key_out_r      <= key_nxt_s;
    end
  end

  // Zero-latency data path keeps ws2812_ctrl request/response timing intact
  assign cfg_num  = blank_s ? NUM_W'(cnt_r) : src_num[32'(active_sel_r)*NUM_W +: NUM_W];
  assign cfg_data = blank_s ? {DATA_W{1'b0}} : src_data[32'(active_sel_r)*DATA_W +: DATA_W];

  assign ws2812_start = ws2812_start_r;
  assign key_out      = key_out_r;
  assign active_sel   = active_sel_r;
  assign switching    = switching_r;

endmodule

// File: tb/tb_ws2812_src_arbiter.sv
// Scoreboard bench for ws2812_src_arbiter: default 4-source instance with blank
// frames, plus a 3-source instance without blank frames.
module tb_ws2812_src_arbiter;

  localparam int NS = 4;
  localparam int SW = 2;
  localparam int KW = 5;
  localparam int NW = 6;
  localparam int DW = 24;
  localparam int LC = 64;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  logic [SW-1:0]     mode_req;
  logic [KW-1:0]     key_in;
  logic [NS-1:0]     src_start;
  logic [NS*NW-1:0]  src_num;
  logic [NS*DW-1:0]  src_data;
  logic              cfg_start;
  logic              ws2812_start;
  logic [NW-1:0]     cfg_num;
  logic [DW-1:0]     cfg_data;
  logic [NS*KW-1:0]  key_out;
  logic [SW-1:0]     active_sel;
  logic              switching;

  logic [SW-1:0]     mode_req5;
  logic [2:0]        src_start5;
  logic [3*NW-1:0]   src_num5;
  logic [3*DW-1:0]   src_data5;
  logic              cfg_start5;
  logic              ws2812_start5;
  logic [NW-1:0]     cfg_num5;
  logic [DW-1:0]     cfg_data5;
  logic [3*KW-1:0]   key_out5;
  logic [SW-1:0]     active_sel5;
  logic              switching5;

  int checks = 0;
  int errors = 0;
  logic [NW+DW-1:0] exp_q[$];

  ws2812_src_arbiter #(
    .NUM_SRC(NS), .SEL_W(SW), .KEY_W(KW), .NUM_W(NW), .DATA_W(DW),
    .LED_CNT(LC), .BLANK_ON_SWITCH(1)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode_req(mode_req), .key_in(key_in),
    .src_start(src_start), .src_num(src_num), .src_data(src_data), .cfg_start(cfg_start),
    .ws2812_start(ws2812_start), .cfg_num(cfg_num), .cfg_data(cfg_data),
    .key_out(key_out), .active_sel(active_sel), .switching(switching)
  );

  ws2812_src_arbiter #(
    .NUM_SRC(3), .SEL_W(SW), .KEY_W(KW), .NUM_W(NW), .DATA_W(DW),
    .LED_CNT(LC), .BLANK_ON_SWITCH(0)
  ) dut5 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode_req(mode_req5), .key_in(key_in),
    .src_start(src_start5), .src_num(src_num5), .src_data(src_data5), .cfg_start(cfg_start5),
    .ws2812_start(ws2812_start5), .cfg_num(cfg_num5), .cfg_data(cfg_data5),
    .key_out(key_out5), .active_sel(active_sel5), .switching(switching5)
  );

  task automatic do_tick;
    @(posedge sys_clk);
    #1;
  endtask

  // Raise cfg_start with fresh source data and queue what the controller must see
  task automatic drive_pulse(input int src, input bit blank, input int idx);
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    n = NW'($urandom_range(0, 63));
    d = DW'($urandom);
    src_num[src*NW +: NW]  = n;
    src_data[src*DW +: DW] = d;
    if (blank) exp_q.push_back({NW'(idx), {DW{1'b0}}});
    else       exp_q.push_back({n, d});
    cfg_start = 1'b1;
    #1;
  endtask

  task automatic end_pulse;
    do_tick;
    cfg_start = 1'b0;
    do_tick;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ws2812_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      do_tick;
    end
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    #2;
    checks++;
    if ({ws2812_start, key_out, active_sel, switching} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b key=%h sel=%0d sw=%b, expected all 0",
               ws2812_start, key_out, active_sel, switching);
    end
    do_tick;
    sys_rst_n = 1'b1;
    do_tick;
    do_tick;
    checks++;
    if ({ws2812_start, active_sel, switching} !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got start=%b sel=%0d sw=%b, expected 0",
               ws2812_start, active_sel, switching);
    end
  endtask

  task automatic test_frame;
    logic [NW+DW-1:0] exp_v;
    src_start = 4'b0001;
    #1;
    checks++;
    if (ws2812_start !== 1'b0) begin
      errors++; $display("FAIL start_early: got %b, expected 0", ws2812_start);
    end
    do_tick;
    src_start = 4'b0000;
    checks++;
    if (ws2812_start !== 1'b1) begin
      errors++; $display("FAIL start_latency: got %b, expected 1", ws2812_start);
    end
    do_tick;
    checks++;
    if (ws2812_start !== 1'b0) begin
      errors++; $display("FAIL start_width: got %b, expected 0", ws2812_start);
    end
    for (int i = 1; i <= LC; i++) begin
      drive_pulse(0, 1'b0, i - 1);
      checks++;
      exp_v = exp_q.pop_front();
      if ({cfg_num, cfg_data} !== exp_v) begin
        errors++;
        $display("FAIL frame_data pulse %0d: got num=%0d data=%h, expected num=%0d data=%h",
                 i, cfg_num, cfg_data, exp_v[NW+DW-1:DW], exp_v[DW-1:0]);
      end
      end_pulse;
    end
    checks++;
    if (switching !== 1'b0 || active_sel !== 2'd0) begin
      errors++; $display("FAIL frame_end_state: got sw=%b sel=%0d, expected 0 0", switching, active_sel);
    end
  endtask

  task automatic test_cancel;
    logic [NW+DW-1:0] exp_v;
    bit found;
    int starts;
    src_start = 4'b0001;
    wait_start(found);
    src_start = 4'b0000;
    checks++;
    if (!found) begin
      errors++; $display("FAIL cancel_frame_start: got no ws2812_start, expected a pulse");
    end
    do_tick;
    for (int i = 1; i <= LC; i++) begin
      if (i == 5)  mode_req = 2'd3;
      if (i == 20) mode_req = 2'd0;
      drive_pulse(0, 1'b0, i - 1);
      checks++;
      exp_v = exp_q.pop_front();
      if ({cfg_num, cfg_data} !== exp_v) begin
        errors++;
        $display("FAIL cancel_data pulse %0d: got num=%0d data=%h, expected num=%0d data=%h",
                 i, cfg_num, cfg_data, exp_v[NW+DW-1:DW], exp_v[DW-1:0]);
      end
      end_pulse;
      if (i == 5 || i == 20) begin
        checks++;
        if (switching !== (i == 5)) begin
          errors++; $display("FAIL cancel_switching pulse %0d: got %b, expected %b", i, switching, (i == 5));
        end
      end
    end
    starts = 0;
    for (int i = 0; i < 6; i++) begin
      if (ws2812_start === 1'b1) starts++;
      do_tick;
    end
    checks++;
    if (starts != 0 || active_sel !== 2'd0 || switching !== 1'b0) begin
      errors++;
      $display("FAIL cancel_no_switch: got starts=%0d sel=%0d sw=%b, expected 0 0 0", starts, active_sel, switching);
    end
  endtask

  task automatic test_switch;
    logic [NW+DW-1:0] exp_v;
    bit found;
    src_start = 4'b0001;
    wait_start(found);
    src_start = 4'b0000;
    do_tick;
    for (int i = 1; i <= LC; i++) begin
      if (i == 11) mode_req = 2'd2;
      drive_pulse(0, 1'b0, i - 1);
      checks++;
      exp_v = exp_q.pop_front();
      if ({cfg_num, cfg_data} !== exp_v) begin
        errors++;
        $display("FAIL switch_old_data pulse %0d: got num=%0d data=%h, expected num=%0d data=%h",
                 i, cfg_num, cfg_data, exp_v[NW+DW-1:DW], exp_v[DW-1:0]);
      end
      end_pulse;
      if (i >= 11 && i < LC) begin
        checks++;
        if (active_sel !== 2'd0 || switching !== 1'b1) begin
          errors++; $display("FAIL switch_pending pulse %0d: got sel=%0d sw=%b, expected 0 1", i, active_sel, switching);
        end
      end
    end
    wait_start(found);
    checks++;
    if (!found || active_sel !== 2'd2 || cfg_data !== 24'd0 || cfg_num !== 6'd0) begin
      errors++;
      $display("FAIL blank_go: got start=%b sel=%0d num=%0d data=%h, expected 1 2 0 0",
               found, active_sel, cfg_num, cfg_data);
    end
    do_tick;
    checks++;
    if (ws2812_start !== 1'b0) begin
      errors++; $display("FAIL blank_start_width: got %b, expected 0", ws2812_start);
    end
    for (int i = 1; i <= LC; i++) begin
      drive_pulse(2, 1'b1, i - 1);
      checks++;
      exp_v = exp_q.pop_front();
      if ({cfg_num, cfg_data} !== exp_v || switching !== 1'b1) begin
        errors++;
        $display("FAIL blank_data pulse %0d: got num=%0d data=%h sw=%b, expected num=%0d data=%h sw=1",
                 i, cfg_num, cfg_data, switching, exp_v[NW+DW-1:DW], exp_v[DW-1:0]);
      end
      end_pulse;
    end
    checks++;
    if (switching !== 1'b0) begin
      errors++; $display("FAIL blank_end_switching: got %b, expected 0", switching);
    end
    src_start = 4'b0100;
    wait_start(found);
    src_start = 4'b0000;
    checks++;
    if (!found) begin
      errors++; $display("FAIL src2_start: got no ws2812_start, expected a pulse");
    end
    do_tick;
    for (int i = 1; i <= LC; i++) begin
      drive_pulse(2, 1'b0, i - 1);
      checks++;
      exp_v = exp_q.pop_front();
      if ({cfg_num, cfg_data} !== exp_v) begin
        errors++;
        $display("FAIL src2_data pulse %0d: got num=%0d data=%h, expected num=%0d data=%h",
                 i, cfg_num, cfg_data, exp_v[NW+DW-1:DW], exp_v[DW-1:0]);
      end
      end_pulse;
    end
  endtask

  task automatic test_keys;
    logic [NW+DW-1:0] exp_v;
    bit found;
    mode_req = 2'd1;
    do_tick;
    checks++;
    if (switching !== 1'b1) begin
      errors++; $display("FAIL key_switch_flag: got %b, expected 1", switching);
    end
    key_in = 5'b00100;
    do_tick;
    key_in = 5'b00000;
    checks++;
    if (key_out !== 20'h00000) begin
      errors++; $display("FAIL key_gated: got %h, expected 00000", key_out);
    end
    wait_start(found);
    checks++;
    if (!found || active_sel !== 2'd1) begin
      errors++; $display("FAIL key_blank_go: got start=%b sel=%0d, expected 1 1", found, active_sel);
    end
    do_tick;
    for (int i = 1; i <= LC; i++) begin
      drive_pulse(1, 1'b1, i - 1);
      checks++;
      exp_v = exp_q.pop_front();
      if ({cfg_num, cfg_data} !== exp_v) begin
        errors++;
        $display("FAIL key_blank_data pulse %0d: got num=%0d data=%h, expected num=%0d data=%h",
                 i, cfg_num, cfg_data, exp_v[NW+DW-1:DW], exp_v[DW-1:0]);
      end
      end_pulse;
    end
    key_in = 5'b00100;
    do_tick;
    key_in = 5'b00000;
    checks++;
    if (key_out !== 20'h00080) begin
      errors++; $display("FAIL key_route: got %h, expected 00080", key_out);
    end
    do_tick;
    checks++;
    if (key_out !== 20'h00000) begin
      errors++; $display("FAIL key_release: got %h, expected 00000", key_out);
    end
    key_in = 5'b10001;
    do_tick;
    key_in = 5'b00000;
    checks++;
    if (key_out !== 20'h00220) begin
      errors++; $display("FAIL key_route2: got %h, expected 00220", key_out);
    end
  endtask

  task automatic test_no_blank;
    bit found;
    int starts;
    src_data5 = {24'h13579B, 24'h5AA53C, 24'hC0FFEE};
    src_num5  = {6'd33, 6'd21, 6'd7};
    mode_req5 = 2'd3;
    do_tick;
    do_tick;
    checks++;
    if (active_sel5 !== 2'd0 || switching5 !== 1'b0) begin
      errors++; $display("FAIL nb_out_of_range: got sel=%0d sw=%b, expected 0 0", active_sel5, switching5);
    end
    mode_req5 = 2'd1;
    found = 1'b0;
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      do_tick;
      if (ws2812_start5 === 1'b1) starts++;
      if (active_sel5 === 2'd1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || starts != 0) begin
      errors++; $display("FAIL nb_switch: got found=%b starts=%0d, expected 1 0", found, starts);
    end
    do_tick;
    checks++;
    if (switching5 !== 1'b0 || ws2812_start5 !== 1'b0 || cfg_data5 !== 24'h5AA53C || cfg_num5 !== 6'd21) begin
      errors++;
      $display("FAIL nb_data: got sw=%b start=%b num=%0d data=%h, expected 0 0 21 5aa53c",
               switching5, ws2812_start5, cfg_num5, cfg_data5);
    end
  endtask

  task automatic test_reset_blank;
    logic [NW+DW-1:0] exp_v;
    bit found;
    mode_req = 2'd3;
    wait_start(found);
    do_tick;
    for (int i = 1; i < 30; i++) begin
      drive_pulse(3, 1'b1, i - 1);
      checks++;
      exp_v = exp_q.pop_front();
      if ({cfg_num, cfg_data} !== exp_v) begin
        errors++;
        $display("FAIL rst_blank_data pulse %0d: got num=%0d data=%h, expected num=%0d data=%h",
                 i, cfg_num, cfg_data, exp_v[NW+DW-1:DW], exp_v[DW-1:0]);
      end
      end_pulse;
    end
    drive_pulse(3, 1'b1, 29);
    checks++;
    if (active_sel !== 2'd3 || switching !== 1'b1) begin
      errors++; $display("FAIL rst_pre_state: got sel=%0d sw=%b, expected 3 1", active_sel, switching);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (ws2812_start !== 1'b0 || key_out !== 20'h00000 || active_sel !== 2'd0 || switching !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got start=%b key=%h sel=%0d sw=%b, expected 0 0 0 0",
               ws2812_start, key_out, active_sel, switching);
    end
    cfg_start = 1'b0;
    mode_req = 2'd0;
    exp_q.delete();
    do_tick;
    do_tick;
    sys_rst_n = 1'b1;
    do_tick;
    src_start = 4'b0001;
    do_tick;
    src_start = 4'b0000;
    checks++;
    if (ws2812_start !== 1'b1) begin
      errors++; $display("FAIL rst_new_frame_start: got %b, expected 1", ws2812_start);
    end
    do_tick;
    for (int i = 1; i <= LC; i++) begin
      drive_pulse(0, 1'b0, i - 1);
      checks++;
      exp_v = exp_q.pop_front();
      if ({cfg_num, cfg_data} !== exp_v) begin
        errors++;
        $display("FAIL rst_new_frame_data pulse %0d: got num=%0d data=%h, expected num=%0d data=%h",
                 i, cfg_num, cfg_data, exp_v[NW+DW-1:DW], exp_v[DW-1:0]);
      end
      end_pulse;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    sys_rst_n  = 1'b0;
    mode_req   = 2'd0;
    key_in     = 5'b00000;
    src_start  = 4'b0000;
    src_num    = {$urandom, $urandom};
    src_data   = {$urandom, $urandom, $urandom};
    cfg_start  = 1'b0;
    mode_req5  = 2'd0;
    src_start5 = 3'b000;
    src_num5   = 18'd0;
    src_data5  = 72'd0;
    cfg_start5 = 1'b0;
    test_reset;
    test_frame;
    test_cancel;
    test_switch;
    test_keys;
    test_no_blank;
    test_reset_blank;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
